// File: rtl/scroll_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_pkg
//  Description : Shared types, default sizes and the terminal-count helper
//                for the scroll position sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package scroll_pkg;

  // Sequencer run state: paused (manual stepping) or auto-scrolling
  typedef enum logic [0:0] {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam int DEF_CNT_W = 24;
  localparam int DEF_SEL_W = 3;
  localparam int DEF_LAST  = 7;

  // Terminal count for a given prescaler width and speed: 2^(cnt_w-speed)-1.
  // Returned at 32 bits so the caller can compare without truncation.
  function automatic logic [31:0] tc_calc(input int cnt_w, input logic [1:0] speed);
    tc_calc = (32'd1 << (cnt_w - int'(speed))) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bit_sync
//  Description : Two-flop synchronizer for a single asynchronous level, with
//                a selectable reset value.
//  Revision    : 1.0  initial release
// ============================================================================
module bit_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply shift the input down the chain
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Both stages clear to the reset value immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/scroll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : scroll_sequencer
//  Description : Position generator for the eight-digit rotating display.
//                Prescaled auto-scroll with run/pause, direction and a
//                single-step pushbutton active only while paused.
//  Revision    : 1.0  initial release
// ============================================================================
module scroll_sequencer
  import scroll_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SEL_W = DEF_SEL_W,
  parameter int LAST  = DEF_LAST
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             RUN,
  input  logic             DIR,
  input  logic [1:0]       SPEED,
  input  logic             KEY_N,
  output logic [SEL_W-1:0] SEL,
  output logic             TICK,
  output logic             WRAP
);

  localparam logic [SEL_W-1:0] C_LAST = SEL_W'(LAST);
  localparam logic [SEL_W-1:0] C_ZERO = '0;

  logic run_s, dir_s, key_s;

  bit_sync #(.RST_VAL(1'b0)) u_sync_run (.clk(CLK), .rst(CLR), .i_d(RUN),   .o_q(run_s));
  bit_sync #(.RST_VAL(1'b0)) u_sync_dir (.clk(CLK), .rst(CLR), .i_d(DIR),   .o_q(dir_s));
  bit_sync #(.RST_VAL(1'b1)) u_sync_key (.clk(CLK), .rst(CLR), .i_d(KEY_N), .o_q(key_s));

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               key_prev_q, key_prev_d;

  logic [31:0]        w_tc;
  logic               w_tc_hit;
  logic               w_key_fall;
  logic               w_step;

  // Next-state logic: step source depends on the current state, so a
  // terminal count in the cycle RUN drops still produces its step.
  always_comb begin
    w_tc       = tc_calc(CNT_W, SPEED);
    // >= lets a speed increase with the count already past the new TC fire next cycle
    w_tc_hit   = (32'(cnt_q) >= w_tc);
    w_key_fall = key_prev_q & ~key_s;
    key_prev_d = key_s;

    state_d = run_s ? RUNNING : PAUSED;

    if (state_q == RUNNING) begin
      w_step = w_tc_hit;
      cnt_d  = w_tc_hit ? '0 : cnt_q + CNT_W'(1);
    end else begin
      w_step = w_key_fall;
      cnt_d  = '0;
    end

    sel_d  = sel_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (w_step) begin
      tick_d = 1'b1;
      if (!dir_s) begin
        if (sel_q == C_LAST) begin
          sel_d  = C_ZERO;
          wrap_d = 1'b1;
        end else begin
          sel_d  = sel_q + SEL_W'(1);
        end
      end else begin
        if (sel_q == C_ZERO) begin
          sel_d  = C_LAST;
          wrap_d = 1'b1;
        end else begin
          sel_d  = sel_q - SEL_W'(1);
        end
      end
    end
  end

  // State, prescaler, edge-detect copy and registered outputs
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= PAUSED;
      cnt_q      <= '0;
      sel_q      <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      key_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      key_prev_q <= key_prev_d;
    end
  end

  assign SEL  = sel_q;
  assign TICK = tick_q;
  assign WRAP = wrap_q;

endmodule
`default_nettype wire

// File: doc/scroll_sequencer.md
Name: scroll_sequencer

Overview:
- Upstream position generator for the eight-digit rotating message display.
- Produces the 3-bit display-select index that the per-digit segment decoder consumes.
- Adds a speed-selectable prescaler, run/pause control, scroll direction and a single-step pushbutton.
- Replaces the free-running counter that previously sat in front of the decoder. That counter was clocked off a derived edge; this block is fully synchronous to CLK.

Parameters:
- CNT_W, 24, prescaler width; the SPEED=0 step period is 2^CNT_W cycles (about 0.34 s at 50 MHz). Must be at least 4.
- SEL_W, 3, width of the position index.
- LAST, 7, highest position value; positions run 0..LAST, and LAST must be at most 2^SEL_W-1.

Ports:
- CLK  in  1  system clock (CLOCK_50 at the top level).
- CLR  in  1  reset, asynchronous, active-high.
- RUN  in  1  switch: 1 = auto-scroll, 0 = paused. Asynchronous to CLK.
- DIR  in  1  switch: 0 = increment SEL, 1 = decrement SEL. Asynchronous to CLK.
- SPEED  in  2  rate select; the step period is 2^(CNT_W-SPEED) cycles. Quasi-static.
- KEY_N  in  1  step pushbutton, active-low, asynchronous. Assumed already debounced on the board.
- SEL  out  SEL_W  current position, registered.
- TICK  out  1  one-cycle pulse, high in the same cycle SEL takes its new value.
- WRAP  out  1  one-cycle pulse, high together with TICK when SEL wraps.

Behaviour:
- Reset: asynchronous, takes effect immediately, including mid-count. Values during and after reset:
  - SEL=0, TICK=0, WRAP=0.
  - Prescaler=0, state=PAUSED.
  - All synchronizer flops are cleared. The KEY_N synchronizer resets to 1 (released).
- Synchronization: RUN, DIR and KEY_N each pass through 2 flops before use, giving 2 cycles of latency. SPEED is used unsynchronized.
- States and transitions:
  - PAUSED -> RUNNING when synced RUN=1.
  - RUNNING -> PAUSED when synced RUN=0.
  - Transitions are evaluated every cycle.
- Prescaler in RUNNING:
  - Increments by 1 each cycle.
  - When count >= TC, where TC = 2^(CNT_W-SPEED)-1, the prescaler clears to 0 and a step fires.
  - The >= comparison handles SPEED being raised while count is above the new TC: the step fires on the next cycle.
- Prescaler in PAUSED: held at 0, so the count restarts from 0 on resume.
- Step sources:
  - RUNNING: prescaler terminal count.
  - PAUSED: a falling edge (1->0) of synced KEY_N, detected against a third registered copy. Exactly one step per press, regardless of hold time.
  - KEY_N edges while RUNNING are ignored.
- Step action, registered on the step cycle's clock edge:
  - DIR=0: SEL <= (SEL==LAST) ? 0 : SEL+1.
  - DIR=1: SEL <= (SEL==0) ? LAST : SEL-1.
  - TICK=1 for exactly one cycle, aligned with the new SEL.
  - WRAP=1 in the same cycle only on LAST->0 (up) or 0->LAST (down).
- Simultaneous events:
  - Terminal count in the same cycle the state leaves RUNNING: the step still fires, because it is decided on the current state; then the block pauses.
  - DIR change is sampled at the step cycle only.
- SEL never leaves 0..LAST. No values outside that range are reachable.
- TICK and WRAP are 0 in every non-step cycle.

Decomposition:
- Package scroll_pkg holds:
  - State enum: PAUSED, RUNNING.
  - Default constants: CNT_W=24, SEL_W=3, LAST=7.
  - A function computing TC from CNT_W and SPEED.
- Sub-module bit_sync: a 2-flop synchronizer with a parameterised reset value, instantiated three times (RUN, DIR, KEY_N).
- Edge detection, prescaler, FSM and position counter live in scroll_sequencer itself.

Test Plan:
All scenarios use CNT_W=4, so the SPEED=0 period is 16 cycles.
- Assert CLR mid-run (SEL=5, prescaler=9), asynchronously between clock edges -> SEL=0, TICK=0, WRAP=0 immediately. After release, no TICK until RUN has been synced high for 2 cycles.
- RUN=1, DIR=0, SPEED=0 -> TICK every 16 cycles. SEL steps 0,1,...,7,0. WRAP=1 only on the 7->0 TICK.
- RUN=1, DIR=1 from SEL=0 -> SEL steps 7 (WRAP=1), 6, 5 on successive TICKs, each 16 cycles apart.
- SPEED switched 0->2 while the prescaler reads 10 -> TICK on the next cycle, then a period of 4 cycles. SPEED=3 -> period of 2 cycles.
- RUN=0, SEL=3, KEY_N held low for 100 cycles -> exactly one TICK with SEL=4, about 3 cycles after the press. Release and re-press -> SEL=5.
- RUN=1, KEY_N pulsed low mid-period -> no extra TICK. The next TICK arrives on the normal 16-cycle boundary.
